// File: rtl/spi_rom_fetch.sv
// spi_rom_fetch: SPI mode-0 master that fetches program bytes from a
// 23LC512-class serial SRAM used as ROM.  Takes a 16-bit fetch address,
// returns one byte with a one-cycle ready pulse.  Sequential fetches
// (addr == previous + 1, 16-bit wrap) stream the next byte with CS held
// low and skip the command/address phase.
//
// Parameters:
//   CLK_DIV  - SCLK half-period in clk cycles (1..255)
//   CMD_READ - SPI read opcode
//   BURST_EN - 1: hold CS between fetches and allow streaming
//              0: every fetch is a full transaction
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   rst_n  in   synchronous active-low reset
//   req    in   fetch request, sampled only while busy = 0
//   addr   in   fetch address, captured on the accepting edge
//   data   out  fetched byte, held until the next ready
//   ready  out  one-cycle pulse: data valid
//   busy   out  high from the accepting edge through the ready cycle
//   sclk   out  SPI clock, idles low
//   cs_n   out  SPI chip select, active low
//   mosi   out  SPI data out, MSB first
//   miso   in   SPI data in
module spi_rom_fetch #(
  parameter int unsigned CLK_DIV  = 1,
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter logic        BURST_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] addr,
  output logic [7:0]  data,
  output logic        ready,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;
  localparam logic [2:0] S_END   = 3'd7;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  state;
  logic [7:0]  div;
  logic [4:0]  bitcnt;      // 0..7 command, 8..23 address, 24..31 data
  logic        sclk_i;
  logic        mosi_i;
  logic        sel;         // internal chip-select, active high
  logic [22:0] tx;          // outgoing bits still to be presented on mosi
  logic [7:0]  rx;
  logic [15:0] fetch_addr;
  logic        fetch_valid;
  logic        pending;     // a new fetch was accepted while CS is being released

  logic        div_done;
  logic        can_accept;
  logic        seq_hit;
  logic        sample;
  logic [7:0]  rx_next;
  logic [15:0] load_addr;

  // The SPI pins, ready and data are registered copies of the internal
  // sequencer one cycle later; busy is driven directly so it rises on the
  // accepting edge.  miso is therefore sampled when the pin-level sclk
  // is high and the internal sclk has already dropped, which is the edge
  // that ends the visible high phase.
  always_comb begin
    div_done   = (div == DIV_LAST);
    can_accept = req && !busy &&
                 (state == S_IDLE || state == S_HOLD || state == S_END);
    seq_hit    = fetch_valid && (addr == fetch_addr + 16'd1);
    sample     = sclk && !sclk_i && (state == S_DATA || state == S_DONE);
    rx_next    = {rx[6:0], miso};
    load_addr  = can_accept ? addr : fetch_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      div         <= '0;
      bitcnt      <= '0;
      sclk_i      <= 1'b0;
      mosi_i      <= 1'b0;
      sel         <= 1'b0;
      tx          <= '0;
      rx          <= '0;
      fetch_addr  <= '0;
      fetch_valid <= 1'b0;
      pending     <= 1'b0;
      data        <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      sclk        <= 1'b0;
      cs_n        <= 1'b1;
      mosi        <= 1'b0;
    end else begin
      cs_n  <= ~sel;
      sclk  <= sclk_i;
      mosi  <= mosi_i;
      ready <= (state == S_DONE);

      if (state == S_DONE) begin
        // with CLK_DIV = 1 the last data bit is sampled on this same edge
        data <= sample ? rx_next : rx;
      end
      if (sample) begin
        rx <= rx_next;
      end

      if (ready) begin
        busy <= 1'b0;
      end
      if (can_accept) begin
        busy        <= 1'b1;
        fetch_addr  <= addr;
        fetch_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (can_accept) begin
            state  <= S_SETUP;
            sel    <= 1'b1;
            div    <= '0;
            mosi_i <= CMD_READ[7];
            tx     <= {CMD_READ[6:0], addr};
          end
        end

        S_SETUP: begin
          if (div_done) begin
            state  <= S_CMD;
            div    <= '0;
            sclk_i <= 1'b1;
            bitcnt <= '0;
          end else begin
            div <= div + 8'd1;
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (!div_done) begin
            div <= div + 8'd1;
          end else begin
            div <= '0;
            if (sclk_i) begin
              // falling edge: present the next outgoing bit
              sclk_i <= 1'b0;
              mosi_i <= tx[22];
              tx     <= {tx[21:0], 1'b0};
            end else begin
              bitcnt <= bitcnt + 5'd1;
              if (bitcnt == 5'd31) begin
                state <= S_DONE;
              end else begin
                sclk_i <= 1'b1;
                if (bitcnt == 5'd7) begin
                  state <= S_ADDR;
                end else if (bitcnt == 5'd23) begin
                  state <= S_DATA;
                end
              end
            end
          end
        end

        S_DONE: begin
          div <= '0;
          if (BURST_EN) begin
            state <= S_HOLD;
          end else begin
            state <= S_END;
            sel   <= 1'b0;
          end
        end

        S_HOLD: begin
          if (can_accept) begin
            div <= '0;
            if (seq_hit) begin
              // device auto-increments: clock out the next byte directly
              state  <= S_DATA;
              sclk_i <= 1'b1;
              bitcnt <= 5'd24;
            end else begin
              state   <= S_END;
              sel     <= 1'b0;
              pending <= 1'b1;
            end
          end
        end

        S_END: begin
          if (can_accept) begin
            pending <= 1'b1;
          end
          if (div_done) begin
            div <= '0;
            if (pending || can_accept) begin
              state   <= S_SETUP;
              sel     <= 1'b1;
              pending <= 1'b0;
              mosi_i  <= CMD_READ[7];
              tx      <= {CMD_READ[6:0], load_addr};
            end else begin
              state <= S_IDLE;
            end
          end else begin
            div <= div + 8'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_fetch.sv
// Bench for spi_rom_fetch: instance 0 runs CLK_DIV=1 with bursting,
// instance 1 runs CLK_DIV=3 without.  Each instance talks to a serial
// SRAM model backed by a shared 64 KiB array.
module tb_spi_rom_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic [1:0]  req;
  logic [1:0]  ready;
  logic [1:0]  busy;
  logic [1:0]  sclk;
  logic [1:0]  cs_n;
  logic [1:0]  mosi;
  logic [15:0] addr [2];
  logic [7:0]  data [2];

  logic [7:0]  mem [0:65535];

  typedef struct {
    int          g;
    logic [7:0]  d;
    int unsigned lat;   // 0: latency not checked
  } exp_t;
  exp_t sb[$];

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned acc_edge [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        sdo = 1'b0;
    int unsigned n = 0;
    logic [22:0] sh = '0;
    logic [7:0]  m_cmd = '0;
    logic [15:0] m_addr = '0;
    int unsigned ncmd = 0;
    int unsigned rcnt = 0;
    int unsigned rises = 0;
    int unsigned hi_run = 0;
    int unsigned last_hi = 0;
    logic        prev_cs = 1'b1;
    logic        prev_rdy = 1'b0;

    spi_rom_fetch #(
      .CLK_DIV (g == 0 ? 1 : 3),
      .CMD_READ(8'h03),
      .BURST_EN(g == 0 ? 1'b1 : 1'b0)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n[g]),
      .req  (req[g]),
      .addr (addr[g]),
      .data (data[g]),
      .ready(ready[g]),
      .busy (busy[g]),
      .sclk (sclk[g]),
      .cs_n (cs_n[g]),
      .mosi (mosi[g]),
      .miso (sdo)
    );

    // serial SRAM: shifts in on rising sclk, drives data after falling sclk
    always @(posedge sclk[g] or negedge sclk[g] or posedge cs_n[g]) begin
      if (cs_n[g]) begin
        n <= 0;
      end else if (sclk[g]) begin
        if (n < 24) sh <= {sh[21:0], mosi[g]};
        if (n == 23) begin
          m_cmd  <= sh[22:15];
          m_addr <= {sh[14:0], mosi[g]};
          ncmd   <= ncmd + 1;
        end
        n <= n + 1;
      end else if (n >= 24) begin
        sdo <= mem[16'(m_addr + 16'((n - 24) >> 3))][3'(7 - ((n - 24) & 7))];
      end
    end

    // monitor: cs_n activity and scoreboard comparison on ready
    always @(negedge clk) begin
      prev_cs  <= cs_n[g];
      prev_rdy <= ready[g];
      if (cs_n[g] && !prev_cs) rises <= rises + 1;
      if (cs_n[g]) begin
        hi_run <= hi_run + 1;
      end else begin
        if (hi_run != 0) last_hi <= hi_run;
        hi_run <= 0;
      end
      if (ready[g]) begin
        exp_t e;
        rcnt <= rcnt + 1;
        check($sformatf("ready_gap%0d", g), prev_rdy, 0);
        check($sformatf("ready_expected%0d", g), sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check($sformatf("ready_inst%0d", g), e.g, g);
          check($sformatf("data%0d", g), data[g], e.d);
          if (e.lat != 0)
            check($sformatf("latency%0d", g), cyc - acc_edge[g], e.lat);
        end
      end
    end
  end

  function automatic int unsigned f_rcnt(input int g);
    return (g == 1) ? g_dut[1].rcnt : g_dut[0].rcnt;
  endfunction
  function automatic int unsigned f_ncmd(input int g);
    return (g == 1) ? g_dut[1].ncmd : g_dut[0].ncmd;
  endfunction
  function automatic int unsigned f_rises(input int g);
    return (g == 1) ? g_dut[1].rises : g_dut[0].rises;
  endfunction

  // called at a negedge; req is held for 'hold' cycles
  task automatic issue(input int g, input logic [15:0] a, input logic [7:0] d,
                       input int unsigned lat, input int hold, input bit push);
    exp_t e;
    req[g]      = 1'b1;
    addr[g]     = a;
    acc_edge[g] = cyc + 1;
    if (push) begin
      e.g = g; e.d = d; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    check($sformatf("busy_after_accept%0d", g), busy[g], 1);
    for (int i = 1; i < hold; i++) @(negedge clk);
    req[g] = 1'b0;
  endtask

  task automatic wait_ready(input int g, input int unsigned max_cyc);
    int unsigned r0 = f_rcnt(g);
    int unsigned k  = 0;
    while (f_rcnt(g) == r0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("ready_within_budget%0d", g), k < max_cyc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r0, nc;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
    mem[16'h1234] = 8'hA5;
    mem[16'h1235] = 8'h5A;
    mem[16'h0100] = 8'hC3;
    mem[16'hFFFF] = 8'h7E;
    mem[16'h0000] = 8'h81;
    mem[16'h2000] = 8'h3C;
    mem[16'h2001] = 8'hE7;

    rst_n = 2'b00;
    req   = 2'b00;
    addr[0] = '0;
    addr[1] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset_pins%0d", g),
            {cs_n[g], sclk[g], mosi[g], ready[g], busy[g]}, 5'b10000);
      check($sformatf("reset_data%0d", g), data[g], 8'h00);
    end
    rst_n = 2'b11;
    repeat (2) @(negedge clk);

    // T1: full fetch
    r0 = f_rises(0);
    nc = f_ncmd(0);
    issue(0, 16'h1234, 8'hA5, 66, 1, 1'b1);
    wait_ready(0, 200);
    check("t1_cmd", g_dut[0].m_cmd, 8'h03);
    check("t1_addr", g_dut[0].m_addr, 16'h1234);
    check("t1_ncmd", f_ncmd(0), nc + 1);
    check("t1_cs_low", f_rises(0), r0);
    repeat (3) @(negedge clk);
    check("hold_state", {cs_n[0], sclk[0], busy[0]}, 3'b000);

    // T2: sequential burst
    r0 = f_rises(0);
    nc = f_ncmd(0);
    issue(0, 16'h1235, 8'h5A, 17, 1, 1'b1);
    wait_ready(0, 100);
    check("t2_no_cs_rise", f_rises(0), r0);
    check("t2_no_cmd", f_ncmd(0), nc);
    repeat (3) @(negedge clk);

    // T3: non-sequential from HOLD
    nc = f_ncmd(0);
    issue(0, 16'h0100, 8'hC3, 0, 1, 1'b1);
    wait_ready(0, 200);
    check("t3_cs_high_cycles", g_dut[0].last_hi, 1);
    check("t3_cmd", g_dut[0].m_cmd, 8'h03);
    check("t3_addr", g_dut[0].m_addr, 16'h0100);
    check("t3_ncmd", f_ncmd(0), nc + 1);
    repeat (3) @(negedge clk);

    // T4: wrap from 0xFFFF to 0x0000 is a burst
    issue(0, 16'hFFFF, 8'h7E, 0, 1, 1'b1);
    wait_ready(0, 200);
    repeat (3) @(negedge clk);
    nc = f_ncmd(0);
    r0 = f_rises(0);
    issue(0, 16'h0000, 8'h81, 17, 1, 1'b1);
    wait_ready(0, 100);
    check("t4_no_cmd", f_ncmd(0), nc);
    check("t4_no_cs_rise", f_rises(0), r0);
    repeat (3) @(negedge clk);

    // T5: reset during the address phase (from IDLE after a reset)
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    issue(0, 16'h4321, 8'h00, 0, 1, 1'b0);
    begin
      int unsigned k = 0;
      while (cyc < acc_edge[0] + 28 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    r0 = f_rcnt(0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    check("t5_after_reset", {cs_n[0], sclk[0], busy[0]}, 3'b100);
    repeat (100) @(negedge clk);
    check("t5_no_ready", f_rcnt(0), r0);
    nc = f_ncmd(0);
    issue(0, 16'h1234, 8'hA5, 66, 1, 1'b1);
    wait_ready(0, 200);
    check("t5_full_txn", f_ncmd(0), nc + 1);

    // T6: CLK_DIV=3, no bursting, req held while busy
    r0 = f_rises(1);
    nc = f_ncmd(1);
    issue(1, 16'h2000, 8'h3C, 196, 20, 1'b1);
    wait_ready(1, 400);
    repeat (10) @(negedge clk);
    check("t6_cs_high_between", f_rises(1), r0 + 1);
    issue(1, 16'h2001, 8'hE7, 196, 20, 1'b1);
    wait_ready(1, 400);
    check("t6_two_full_txns", f_ncmd(1), nc + 2);
    repeat (250) @(negedge clk);
    check("t6_ready_count", f_rcnt(1), 2);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
